// File: rtl/vector_writeback_unit.sv
// vector_writeback_unit: merges ALU and load results into an ordered FIFO
// and drives the vector register file's single write port, one write per
// cycle. Also exports a per-register pending-write mask for issue stalls.
//
// Handshake: a producer's result is accepted on a rising edge exactly when
// its valid and ready are both 1 on that edge. Ready never depends on data or
// hold, and valid must not depend on ready. At most one source is accepted
// per edge. When both sources are valid, the round-robin bit picks which one
// sees ready.
module vector_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              hold,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [NREG-1:0]   pending,
  output logic [CNT_W-1:0]  count
);

  // FIFO storage; contents need no reset because occupancy qualifies them
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic              rr;           // 0: ALU favoured, 1: load favoured

  logic              space;
  logic              both_valid;
  logic              alu_take;
  logic              ld_take;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // Space uses registered occupancy only, so a full FIFO never pops through
  assign space      = (occ < CNT_W'(DEPTH));
  assign both_valid = alu_valid & ld_valid;

  // Ready: blocked in reset; under contention only the favoured side sees it
  assign alu_ready = ~rst & space & (~both_valid | ~rr);
  assign ld_ready  = ~rst & space & (~both_valid |  rr);

  assign alu_take  = alu_valid & alu_ready;
  assign ld_take   = ld_valid  & ld_ready;
  assign push      = alu_take | ld_take;
  assign pop       = ~rst & (occ != '0) & ~hold;

  // Select the accepted source's payload
  always_comb begin
    push_addr = alu_addr;
    push_data = alu_data;
    if (ld_take) begin
      push_addr = ld_addr;
      push_data = ld_data;
    end
  end

  // Write accepted entries into the FIFO slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, arbitration state and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      rr      <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        wb_addr <= mem_addr[rd_ptr];
        wb_data <= mem_data[rd_ptr];
      end
      wb_en <= pop;
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      if (both_valid && push) begin
        rr <= ~rr;
      end
    end
  end

  // Pending mask: every occupied slot plus the entry currently on the port
  logic [PTR_W-1:0] slot_off;
  logic [NREG-1:0]  pend;
  always_comb begin
    pend     = '0;
    slot_off = '0;
    for (int j = 0; j < DEPTH; j++) begin
      // Distance from the head, modulo DEPTH; slot is live if within occupancy
      slot_off = PTR_W'(j) - rd_ptr;
      if (CNT_W'(slot_off) < occ) begin
        pend[mem_addr[j]] = 1'b1;
      end
    end
    if (wb_en) begin
      pend[wb_addr] = 1'b1;
    end
  end

  assign pending = pend;
  assign count   = occ;

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Self-checking bench for vector_writeback_unit: scenario tasks with inline
// checks, plus a scoreboard of accepted requests checked against the port.
module tb_vector_writeback_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int NREG   = 2 ** ADDR_W;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              hold;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  vector_writeback_unit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .hold     (hold),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .pending  (pending),
    .count    (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard push: record each handshake seen on an edge; reset drops all
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (alu_valid && alu_ready) exp_q.push_back({alu_addr, alu_data});
      if (ld_valid && ld_ready)   exp_q.push_back({ld_addr, ld_data});
    end
  end

  // Scoreboard pop: every write on the port must match the oldest accept
  always @(negedge clk) begin
    if (wb_en) begin
      logic [W-1:0] exp_e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, expected no write", wb_addr, wb_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({wb_addr, wb_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wb_addr, wb_data, exp_e[W-1:DATA_W], exp_e[DATA_W-1:0]);
        end
      end
    end
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic drive_alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_alu(3'd2, 32'h55);
    step();
    drive_alu(3'd2, 32'h56);
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low: got alu_ready=%b ld_ready=%b, expected 0 0", alu_ready, ld_ready);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b0 || wb_addr !== '0 || wb_data !== '0 || count !== '0 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got wb_en=%b addr=%0d data=%h count=%0d pending=%h, expected all zero",
               wb_en, wb_addr, wb_data, count, pending);
    end
    rst = 1'b0;
    idle();
    #1;
    tests_run++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after: got alu_ready=%b ld_ready=%b, expected 1 1", alu_ready, ld_ready);
    end
    step();
  endtask

  task automatic test_single();
    drive_alu(3'd3, 32'hDEADBEEF);
    #1;
    tests_run++;
    if (alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready: got %b, expected 1", alu_ready);
    end
    step();
    idle();
    tests_run++;
    if (pending !== 8'h08 || wb_en !== 1'b0 || count !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL single_after_accept: got pending=%h wb_en=%b count=%0d, expected 08 0 1", pending, wb_en, count);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 32'hDEADBEEF || pending !== 8'h08) begin
      tests_failed++;
      $display("FAIL single_write: got wb_en=%b addr=%0d data=%h pending=%h, expected 1 3 deadbeef 08",
               wb_en, wb_addr, wb_data, pending);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b0 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_done: got wb_en=%b pending=%h, expected 0 00", wb_en, pending);
    end
  endtask

  task automatic test_contention();
    drive_alu(3'd1, 32'h11);
    drive_ld(3'd2, 32'h22);
    for (int i = 0; i < 6; i++) begin
      logic exp_alu;
      exp_alu = (i % 2 == 0);
      #1;
      tests_run++;
      if (alu_ready !== exp_alu || ld_ready !== ~exp_alu) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got alu_ready=%b ld_ready=%b, expected %b %b",
                 i, alu_ready, ld_ready, exp_alu, ~exp_alu);
      end
      step();
      if (i >= 1) begin
        logic [ADDR_W-1:0] exp_a;
        exp_a = ((i - 1) % 2 == 0) ? 3'd1 : 3'd2;
        tests_run++;
        if (wb_en !== 1'b1 || wb_addr !== exp_a) begin
          tests_failed++;
          $display("FAIL contention_write%0d: got wb_en=%b addr=%0d, expected 1 %0d", i, wb_en, wb_addr, exp_a);
        end
      end
    end
    idle();
    step();
    tests_run++;
    if (wb_en !== 1'b1 || wb_addr !== 3'd2) begin
      tests_failed++;
      $display("FAIL contention_last: got wb_en=%b addr=%0d, expected 1 2", wb_en, wb_addr);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b0 || count !== '0) begin
      tests_failed++;
      $display("FAIL contention_idle: got wb_en=%b count=%0d, expected 0 0", wb_en, count);
    end
  endtask

  task automatic test_full();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_alu(ADDR_W'(k), 32'h100 + k);
      #1;
      tests_run++;
      if (alu_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_fill_ready%0d: got %b, expected 1", k, alu_ready);
      end
      step();
    end
    drive_alu(3'd4, 32'h104);
    #1;
    tests_run++;
    if (count !== CNT_W'(4) || alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_blocked: got count=%0d alu_ready=%b ld_ready=%b, expected 4 0 0", count, alu_ready, ld_ready);
    end
    step();
    tests_run++;
    if (count !== CNT_W'(4) || wb_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_hold: got count=%0d wb_en=%b, expected 4 0", count, wb_en);
    end
    hold = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      tests_run++;
      if (wb_en !== 1'b1 || wb_addr !== ADDR_W'(e) || wb_data !== 32'h100 + e) begin
        tests_failed++;
        $display("FAIL full_drain%0d: got wb_en=%b addr=%0d data=%h, expected 1 %0d %h",
                 e, wb_en, wb_addr, wb_data, e, 32'h100 + e);
      end
      if (e == 0) begin
        tests_run++;
        if (alu_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL full_reopen: got alu_ready=%b, expected 1", alu_ready);
        end
      end
      if (e == 1) idle();
    end
    step();
    tests_run++;
    if (wb_en !== 1'b0 || count !== '0) begin
      tests_failed++;
      $display("FAIL full_empty: got wb_en=%b count=%0d, expected 0 0", wb_en, count);
    end
  endtask

  task automatic test_waw();
    drive_alu(3'd5, 32'hA);
    step();
    idle();
    drive_ld(3'd5, 32'hB);
    tests_run++;
    if (pending !== 8'h20) begin
      tests_failed++;
      $display("FAIL waw_pending1: got %h, expected 20", pending);
    end
    step();
    idle();
    tests_run++;
    if (wb_en !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 32'hA || pending !== 8'h20) begin
      tests_failed++;
      $display("FAIL waw_first: got wb_en=%b addr=%0d data=%h pending=%h, expected 1 5 a 20",
               wb_en, wb_addr, wb_data, pending);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 32'hB || pending !== 8'h20) begin
      tests_failed++;
      $display("FAIL waw_second: got wb_en=%b addr=%0d data=%h pending=%h, expected 1 5 b 20",
               wb_en, wb_addr, wb_data, pending);
    end
    step();
    tests_run++;
    if (wb_en !== 1'b0 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL waw_clear: got wb_en=%b pending=%h, expected 0 00", wb_en, pending);
    end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    drive_alu(3'd6, 32'h66);
    drive_ld(3'd1, 32'h77);
    step();
    idle();
    drive_alu(3'd7, 32'h70);
    step();
    drive_alu(3'd0, 32'h80);
    step();
    idle();
    tests_run++;
    if (count !== CNT_W'(3) || pending !== 8'hC1) begin
      tests_failed++;
      $display("FAIL mid_queued: got count=%0d pending=%h, expected 3 c1", count, pending);
    end
    rst = 1'b1;
    step();
    rst  = 1'b0;
    hold = 1'b0;
    tests_run++;
    if (count !== '0 || pending !== 8'h00 || wb_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got count=%0d pending=%h wb_en=%b, expected 0 00 0", count, pending, wb_en);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (wb_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_no_write%0d: got wb_en=%b, expected 0", c, wb_en);
      end
    end
    drive_alu(3'd1, 32'h91);
    drive_ld(3'd2, 32'h92);
    #1;
    tests_run++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rr_reset: got alu_ready=%b ld_ready=%b, expected 1 0", alu_ready, ld_ready);
    end
    step();
    idle();
  endtask

  // Test sequence and final report
  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    ld_addr   = '0;
    ld_data   = '0;
    step();
    step();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_waw();
    test_reset_mid();
    repeat (8) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drained: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
